// File: rtl/stage_muldiv.sv
// -----------------------------------------------------------------------------
// stage_muldiv
//   Multiply/divide unit beside the execute stage. It owns the HI/LO registers
//   and models a fixed multi-cycle latency. While an operation is in flight,
//   `busy` is high so that decode can stall md-class instructions.
//
//   When the op is accepted, the result is computed from the operands and held
//   in a pending register. It is copied into HI/LO on the edge where the
//   latency counter steps from 1 to 0. This keeps HI/LO from ever showing a
//   partial result.
//
//   Optional feature: define MULDIV_MADD_EN to enable op 7 (madd). In the
//   default build (macro undefined), op 7 behaves like op 0.
//
// Ports
//   clk    in   clock; all state updates on the rising edge
//   reset  in   synchronous, active-high reset
//   op     in   [2:0]  0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                      5 mthi, 6 mtlo, 7 madd (feature-gated)
//   src0   in   [31:0] rs operand (already forwarded)
//   src1   in   [31:0] rt operand (already forwarded)
//   busy   out  operation in flight
//   hi     out  [31:0] HI register
//   lo     out  [31:0] LO register
// -----------------------------------------------------------------------------
module stage_muldiv #(
  parameter int unsigned MULT_LATENCY = 5,
  parameter int unsigned DIV_LATENCY  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif

  localparam logic [3:0] MULT_CNT = 4'(MULT_LATENCY);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LATENCY);

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
`ifdef MULDIV_MADD_EN
  logic [63:0] madd_sum;
`endif

  assign prod_s = $signed({{32{src0[31]}}, src0}) * $signed({{32{src1[31]}}, src1});
  assign prod_u = {32'd0, src0} * {32'd0, src1};
`ifdef MULDIV_MADD_EN
  // HI/LO are frozen while busy, so the accept-time value is also the commit-time base.
  assign madd_sum = {hi_q, lo_q} + prod_s;
`endif

  // One unsigned divider serves both div and divu. For signed div, it works on
  // magnitudes, and the signs are applied afterwards: the quotient truncates
  // toward zero, and the remainder follows the dividend. The magnitude of
  // 0x80000000 is 2^31, which still fits in 32 unsigned bits, so
  // 0x80000000 / -1 yields 0x80000000 rem 0 without a special case.
  logic        div_signed;
  logic        div_zero;
  logic [31:0] dvd_mag, dvs_mag, quo_mag, rem_mag, quo, rem;

  assign div_signed = (op == OP_DIV);
  assign div_zero   = (src1 == 32'd0);
  assign dvd_mag    = (div_signed && src0[31]) ? -src0 : src0;
  // The divisor is forced to 1 on divide-by-zero only to keep the datapath
  // well defined. The result is never committed in that case.
  assign dvs_mag    = div_zero ? 32'd1 : ((div_signed && src1[31]) ? -src1 : src1);
  assign quo_mag    = dvd_mag / dvs_mag;
  assign rem_mag    = dvd_mag % dvs_mag;
  assign quo        = (div_signed && (src0[31] ^ src1[31])) ? -quo_mag : quo_mag;
  assign rem        = (div_signed && src0[31]) ? -rem_mag : rem_mag;

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    if (cnt_q != 4'd0) begin
      // In flight: every incoming op is ignored.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else begin
      case (op)
        OP_MULT: begin
          cnt_d                  = MULT_CNT;
          {pend_hi_d, pend_lo_d} = prod_s;
          pend_wr_d              = 1'b1;
        end
        OP_MULTU: begin
          cnt_d                  = MULT_CNT;
          {pend_hi_d, pend_lo_d} = prod_u;
          pend_wr_d              = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          cnt_d     = DIV_CNT;
          pend_hi_d = rem;
          pend_lo_d = quo;
          pend_wr_d = !div_zero;
        end
        OP_MTHI: hi_d = src0;
        OP_MTLO: lo_d = src0;
`ifdef MULDIV_MADD_EN
        OP_MADD: begin
          cnt_d                  = MULT_CNT;
          {pend_hi_d, pend_lo_d} = madd_sum;
          pend_wr_d              = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = (cnt_q != 4'd0);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_stage_muldiv.sv
// -----------------------------------------------------------------------------
// tb_stage_muldiv
//   Directed bench for stage_muldiv. Inputs are driven on the falling edge and
//   outputs are sampled there too. The table entries run back to back: each
//   new op is presented in the first cycle in which busy reads 0.
// -----------------------------------------------------------------------------
module tb_stage_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic [31:0] src0, src1;
  logic        busy;
  logic [31:0] hi, lo;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stage_muldiv #(.MULT_LATENCY(5), .DIV_LATENCY(10)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .src0  (src0),
    .src1  (src1),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Called at a falling edge with busy low. Presents one op for one edge,
  // counts the busy cycles that follow, and confirms HI/LO hold while busy.
  // It returns at the first falling edge where busy is low again.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] eh, input logic [31:0] el,
                        input string nm);
    logic [31:0] ph, pl;
    int n;
    logic held;
    ph = hi; pl = lo;
    op = o; src0 = a; src1 = b;
    @(negedge clk);
    op = 3'd0;
    n = 0; held = 1'b1;
    while (busy && n < 40) begin
      if (hi !== ph || lo !== pl) held = 1'b0;
      n++;
      @(negedge clk);
    end
    check({nm, " busy_cycles"}, 32'(n), 32'(lat));
    check({nm, " hold_while_busy"}, {31'd0, held}, 32'd1);
    check({nm, " hi"}, hi, eh);
    check({nm, " lo"}, lo, el);
  endtask

  initial begin
    int n;
    logic ign_ok;

    vecs[0]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        5,  32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5"};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE, "multu_max_x2"};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2"};
    vecs[3]  = '{3'd5, 32'h00000011, 32'd0,        0,  32'h00000011, 32'hFFFFFFFD, "mthi_11"};
    vecs[4]  = '{3'd6, 32'h00000022, 32'd0,        0,  32'h00000011, 32'h00000022, "mtlo_22"};
    vecs[5]  = '{3'd4, 32'd7,        32'd0,        10, 32'h00000011, 32'h00000022, "divu_by_zero"};
    vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_overflow"};
    vecs[7]  = '{3'd5, 32'hDEADBEEF, 32'd0,        0,  32'hDEADBEEF, 32'h80000000, "mthi_deadbeef"};
    vecs[8]  = '{3'd6, 32'h12345678, 32'd0,        0,  32'hDEADBEEF, 32'h12345678, "mtlo_12345678"};
    vecs[9]  = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001, "mult_maxpos_sq"};
    vecs[10] = '{3'd4, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E, "divu_100_7"};
    vecs[11] = '{3'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, "div_7_neg2"};
    vecs[12] = '{3'd2, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000, "multu_2p32"};
    vecs[13] = '{3'd0, 32'd5,        32'd5,        0,  32'h00000001, 32'h00000000, "op_none"};
    vecs[14] = '{3'd5, 32'h00000000, 32'd0,        0,  32'h00000000, 32'h00000000, "mthi_0"};
    vecs[15] = '{3'd6, 32'hFFFFFFFF, 32'd0,        0,  32'h00000000, 32'hFFFFFFFF, "mtlo_ones"};
`ifdef MULDIV_MADD_EN
    vecs[16] = '{3'd7, 32'd1,        32'd1,        5,  32'h00000001, 32'h00000000, "madd_carry"};
`else
    vecs[16] = '{3'd7, 32'd1,        32'd1,        0,  32'h00000000, 32'hFFFFFFFF, "op7_disabled"};
`endif

    reset = 1'b1; op = 3'd0; src0 = 32'd0; src1 = 32'd0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].name);

    // While a mult is in flight, present mthi and then div. Neither may take
    // effect, and the mult must not restart.
    op = 3'd1; src0 = 32'd6; src1 = 32'd7;
    @(negedge clk);
    op = 3'd5; src0 = 32'hAAAAAAAA; src1 = 32'd0;
    n = 0; ign_ok = 1'b1;
    while (busy && n < 40) begin
      if (n == 1) begin op = 3'd3; src0 = 32'd100; src1 = 32'd3; end
      if (n == 2) op = 3'd0;
      if (hi === 32'hAAAAAAAA) ign_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    op = 3'd0;
    check("ignore_busy busy_cycles", 32'(n), 32'd5);
    check("ignore_busy no_mthi", {31'd0, ign_ok}, 32'd1);
    check("ignore_busy hi", hi, 32'd0);
    check("ignore_busy lo", lo, 32'h0000002A);
    @(negedge clk);
    check("ignore_busy idle", {31'd0, busy}, 32'd0);

    // Reset asserted in the third busy cycle of a mult aborts the mult.
    run_op(3'd5, 32'h00000005, 32'd0, 0, 32'h00000005, 32'h0000002A, "pre_reset_mthi");
    op = 3'd1; src0 = 32'd6; src1 = 32'd7;
    @(negedge clk);
    op = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("abort in_flight", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    repeat (8) @(negedge clk);
    check("abort no_commit busy", {31'd0, busy}, 32'd0);
    check("abort no_commit hi", hi, 32'd0);
    check("abort no_commit lo", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_muldiv.md
Name: stage_muldiv

Overview:
- Multiply/divide unit beside the execute stage of the 5-stage pipeline; owns the HI/LO registers.
- Consumes the forwarded execute-stage operands (`e_read_data0`/`e_read_data1` equivalents) plus a decoded op.
- Models a fixed multi-cycle latency.
- Exports `busy` so the top-level hazard logic stalls decode on mult/div/mfhi/mflo/mthi/mtlo while an operation is in flight.

Parameters:
- MULT_LATENCY, 5, busy cycles for mult/multu (and madd when enabled); legal range 1..15.
- DIV_LATENCY, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd (feature-gated).
- src0  input  32  rs operand (already forwarded).
- src1  input  32  rt operand (already forwarded).
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: busy=0, hi=0, lo=0, internal counter=0, pending result cleared.
- Reset mid-operation aborts the operation; HI/LO become 0 and the pending result is discarded.
- Accept rule: op sampled on each posedge.
  - op 1..4 (or 7) while busy=0 is accepted: src0/src1 and op are latched, and counter is loaded with the matching latency.
  - Any op other than 0 while busy=1 is ignored, with no effect on state. Upstream stalling guarantees this never occurs; the bench still checks it.
- busy = (counter != 0).
  - Accept at edge T gives busy high for exactly LATENCY cycles after T.
  - Counter decrements by 1 per edge while nonzero.
- Commit:
  - On the edge where the counter goes 1 to 0, hi/lo take the pending result.
  - New values are visible in the same cycle busy first reads 0.
  - hi/lo never show partial results while busy.
- mthi/mtlo (op 5/6) with busy=0: hi (resp. lo) <= src0 on that edge. No busy cycles; the other register is unchanged.
- Arithmetic:
  - mult: {hi,lo} = signed 32x32 -> 64-bit product.
  - multu: unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (src1=0, div or divu):
  - Still busy for DIV_LATENCY.
  - hi/lo are left unchanged at commit.
  - No exception.
- Signed overflow case div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Back-to-back: a new op presented in the cycle busy first reads 0 is accepted. Zero dead cycles between operations.
- Reads: hi/lo are plain register outputs. mfhi/mflo read them combinationally in the decode or execute stage once no stall is pending.
- Top-level stall contract, part of this block's interface:
  - Decode stalls any md-class instruction while busy=1.
  - Decode also stalls while the execute-stage op is 1..4 or 7, covering the accept cycle.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined: op 7 = madd. {hi,lo} <= {hi,lo} + signed(src0)*signed(src1), computed modulo 2^64. Latency MULT_LATENCY. The accumulate base is the HI/LO value at commit time, which equals the value at accept because HI/LO cannot change while busy.
- Not defined: op 7 is treated as op 0 (no effect, busy stays 0).

Test Plan:
- mult src0=0xFFFFFFFD (-3), src1=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1. During busy, hi/lo still hold prior values.
- multu src0=0xFFFFFFFF, src1=2 -> hi=0x00000001, lo=0xFFFFFFFE. Then div src0=0xFFFFFFF9 (-7), src1=2 issued in the first non-busy cycle -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu src0=7, src1=0 with hi=0x11, lo=0x22 beforehand -> busy 10 cycles; hi=0x11, lo=0x22 unchanged. Then div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi src0=0xDEADBEEF, then mtlo src0=0x12345678 -> hi/lo updated on their respective edges, busy never asserted. mthi presented while busy -> ignored.
- Start mult 6*7, assert reset on the 3rd busy cycle -> busy=0, hi=0, lo=0 next cycle; no commit afterwards.
- (MULDIV_MADD_EN) hi=0, lo=0xFFFFFFFF, madd 1*1 -> hi=1, lo=0. Without the macro, the same stimulus leaves hi=0, lo=0xFFFFFFFF and busy=0.
